// File: rtl/sa_tlb.sv
// Set-associative TLB: combinational lookup, MMU refill on miss,
// round-robin replacement, hit-under-miss and sfence.vma flush.
module sa_tlb #(
  parameter int VPN_BITS    = 36,
  parameter int PPN_BITS    = 44,
  parameter int OFFSET_BITS = 12,
  parameter int ADDR_W      = 64,
  parameter int WAYS        = 4,
  parameter int SETS        = 64,
  parameter int PERM_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              va_valid,
  input  logic [ADDR_W-1:0] va,
  output logic              pa_valid,
  output logic [ADDR_W-1:0] pa,
  output logic [PERM_W-1:0] pte_perm,
  output logic              busy,
  input  logic              flush_all,
  input  logic              flush_va_valid,
  input  logic [ADDR_W-1:0] flush_va,
  output logic              req_valid,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [ADDR_W-1:0] resp_addr,
  input  logic [PERM_W-1:0] resp_perm
);

  localparam int LS = $clog2(SETS);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int OF = OFFSET_BITS;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, state_nx;

  logic [WAYS-1:0]     vld   [SETS];
  logic [VPN_BITS-1:0] tags  [SETS][WAYS];
  logic [PPN_BITS-1:0] ppns  [SETS][WAYS];
  logic [PERM_W-1:0]   perms [SETS][WAYS];
  logic [WW-1:0]       rr    [SETS];

  logic                drop;
  logic [VPN_BITS-1:0] miss_vpn;

  logic [LS-1:0]       idx;
  logic [VPN_BITS-1:0] vtag;
  logic                hit;
  logic [PPN_BITS-1:0] hit_ppn;
  logic [PERM_W-1:0]   hit_perm;

  assign idx  = va[OF+LS-1:OF];
  assign vtag = va[OF+VPN_BITS-1:OF];

  always_comb begin
    hit      = 1'b0;
    hit_ppn  = '0;
    hit_perm = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (vld[idx][w] && tags[idx][w] == vtag) begin
        hit      = va_valid;
        hit_ppn  = ppns[idx][w];
        hit_perm = perms[idx][w];
      end
    end
  end

  always_comb begin
    pa       = '0;
    pte_perm = '0;
    if (hit) begin
      pa[OF+PPN_BITS-1:0] = {hit_ppn, va[OF-1:0]};
      pte_perm            = hit_perm;
    end
  end

  assign pa_valid = hit;
  assign busy     = (state == S_WAIT);

  // Flush-by-VA match in flush_va's own set
  logic [LS-1:0]       fidx;
  logic [VPN_BITS-1:0] ftag;
  logic [WAYS-1:0]     fmatch;

  assign fidx = flush_va[OF+LS-1:OF];
  assign ftag = flush_va[OF+VPN_BITS-1:OF];

  always_comb begin
    fmatch = '0;
    for (int w = 0; w < WAYS; w++)
      fmatch[w] = vld[fidx][w] && tags[fidx][w] == ftag;
  end

  // Victim: existing match, else lowest invalid, else rr
  logic [LS-1:0] midx;
  logic          found_m, found_i, use_rr;
  logic [WW-1:0] m_way, i_way, victim, rr_nx;

  assign midx = miss_vpn[LS-1:0];

  always_comb begin
    found_m = 1'b0;
    found_i = 1'b0;
    m_way   = '0;
    i_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_m && vld[midx][w] &&
          tags[midx][w] == miss_vpn) begin
        found_m = 1'b1;
        m_way   = WW'(w);
      end
      if (!found_i && !vld[midx][w]) begin
        found_i = 1'b1;
        i_way   = WW'(w);
      end
    end
    use_rr = !found_m && !found_i;
    victim = found_m ? m_way :
             found_i ? i_way : rr[midx];
    rr_nx  = (rr[midx] == WW'(WAYS - 1)) ?
             '0 : rr[midx] + 1'b1;
  end

  logic flush_any, miss, fill_en;

  assign flush_any = flush_all | flush_va_valid;
  assign miss      = (state == S_IDLE) && va_valid &&
                     !hit && !flush_any;
  assign fill_en   = (state == S_WAIT) && resp_valid &&
                     !drop && !flush_any;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (miss)       state_nx = S_WAIT;
      S_WAIT: if (resp_valid) state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
      req_addr  <= '0;
      drop      <= 1'b0;
    end else begin
      state <= state_nx;
      if (miss) begin
        req_valid <= 1'b1;
        req_addr  <= {va[ADDR_W-1:OF], {OF{1'b0}}};
      end else if (busy && resp_valid) begin
        req_valid <= 1'b0;
      end
      if (busy) begin
        if (resp_valid)     drop <= 1'b0;
        else if (flush_any) drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (miss) miss_vpn <= vtag;
    if (fill_en) begin
      tags[midx][victim]  <= miss_vpn;
      ppns[midx][victim]  <= resp_addr[OF+PPN_BITS-1:OF];
      perms[midx][victim] <= resp_perm;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_all) begin
      for (int s = 0; s < SETS; s++) begin
        vld[s] <= '0;
        rr[s]  <= '0;
      end
    end else begin
      if (flush_va_valid)
        vld[fidx] <= vld[fidx] & ~fmatch;
      if (fill_en) begin
        vld[midx][victim] <= 1'b1;
        if (use_rr) rr[midx] <= rr_nx;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{flush_va[ADDR_W-1:OF+VPN_BITS],
                         flush_va[OF-1:0],
                         resp_addr[ADDR_W-1:OF+PPN_BITS],
                         resp_addr[OF-1:0]};

endmodule
